// File: rtl/cim_bitserial_mac_array_if.sv
// Handshake bundle for cim_bitserial_mac_array: weight, activation and result
// channels. The master modport is the host side, the slave modport the engine.
interface cim_bitserial_mac_array_if #(
   parameter int NUM_STACKS = 8,
   parameter int NUM_INPUTS = 8,
   parameter int WT_WIDTH   = 8,
   parameter int ACT_WIDTH  = 8,
   parameter int ACC_WIDTH  = 24
);
   logic                                     wt_valid;
   logic                                     wt_ready;
   logic [NUM_STACKS*WT_WIDTH-1:0]           wt_data;
   logic                                     act_valid;
   logic                                     act_ready;
   logic [NUM_STACKS*NUM_INPUTS*ACT_WIDTH-1:0] act_data;
   logic                                     res_valid;
   logic                                     res_ready;
   logic [NUM_STACKS*ACC_WIDTH-1:0]          res_data;

   modport master (
      output wt_valid, wt_data, act_valid, act_data, res_ready,
      input  wt_ready, act_ready, res_valid, res_data
   );

   modport slave (
      input  wt_valid, wt_data, act_valid, act_data, res_ready,
      output wt_ready, act_ready, res_valid, res_data
   );
endinterface

// File: rtl/cim_bitserial_mac_array.sv
// Multi-stack bit-serial compute-in-memory MAC engine.
// Each stack holds NUM_INPUTS signed weights; activation vectors are streamed
// LSB first, one bit-plane per cycle, and accumulated over cfg_num_vec vectors.
// act_data layout: stack s, input i occupies bits [(s*NUM_INPUTS+i)*ACT_WIDTH +: ACT_WIDTH].
// Optional macro CIM_MAC_SATURATE_EN: clamp the accumulator on overflow instead
// of two's-complement wrap (overflow flag is set either way).
module cim_bitserial_mac_array #(
   parameter int NUM_STACKS = 8,
   parameter int NUM_INPUTS = 8,
   parameter int WT_WIDTH   = 8,
   parameter int ACT_WIDTH  = 8,
   parameter int ACC_WIDTH  = 24,
   parameter int VEC_CNT_W  = 16
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic                           cfg_reload_wt,
   input  logic [$clog2(ACT_WIDTH+1)-1:0] cfg_act_bits,
   input  logic                           cfg_signed,
   input  logic [VEC_CNT_W-1:0]           cfg_num_vec,
   cim_bitserial_mac_array_if.slave       bus,
   output logic [NUM_STACKS-1:0]          overflow,
   output logic                           busy,
   output logic                           done
);

   localparam int AB_W  = $clog2(ACT_WIDTH+1);
   localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int PW    = WT_WIDTH + $clog2(NUM_INPUTS);
   // Wide enough for acc +/- (P << (ACT_WIDTH-1)) without losing the true sum.
   localparam int TW    = ((ACC_WIDTH > PW + ACT_WIDTH) ? ACC_WIDTH : PW + ACT_WIDTH) + 2;

   localparam logic [AB_W-1:0]      ACT_MAX  = AB_W'(ACT_WIDTH);
   localparam logic [IDX_W-1:0]     LAST_ROW = IDX_W'(NUM_INPUTS - 1);
   localparam logic [ACC_WIDTH-1:0] ACC_POS  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_NEG  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOAD_W  = 2'd1;
   localparam logic [1:0] S_COMPUTE = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   logic [1:0]                                 state;
   logic signed [WT_WIDTH-1:0]                 weights [NUM_STACKS][NUM_INPUTS];
   logic signed [ACC_WIDTH-1:0]                acc     [NUM_STACKS];
   logic [NUM_STACKS*NUM_INPUTS*ACT_WIDTH-1:0] shadow;
   logic [AB_W-1:0]                            last_idx_q;
   logic [AB_W-1:0]                            bit_idx;
   logic                                       signed_q;
   logic [VEC_CNT_W-1:0]                       num_q;
   logic [VEC_CNT_W-1:0]                       accepted;
   logic                                       in_flight;
   logic [IDX_W-1:0]                           wt_beat;
   logic                                       done_q;

   logic                                       start_ok;
   logic                                       last_bit;
   logic                                       neg_bit;
   logic                                       wt_fire;
   logic                                       act_fire;
   logic                                       res_fire;

   logic [ACT_WIDTH-1:0]                       act_word;
   logic [ACT_WIDTH-1:0]                       act_col;
   logic [TW-ACC_WIDTH:0]                      sum_hi;
   logic signed [PW-1:0]                       psum     [NUM_STACKS];
   logic signed [TW-1:0]                       term     [NUM_STACKS];
   logic signed [TW-1:0]                       sum      [NUM_STACKS];
   logic signed [ACC_WIDTH-1:0]                acc_next [NUM_STACKS];
   logic [NUM_STACKS-1:0]                      acc_ovf;

   // Handshake and status decode
   always_comb begin
      start_ok = (cfg_act_bits != '0) && (cfg_act_bits <= ACT_MAX) && (cfg_num_vec != '0);
      last_bit = in_flight && (bit_idx == last_idx_q);
      neg_bit  = signed_q && (bit_idx == last_idx_q);

      bus.wt_ready  = (state == S_LOAD_W);
      bus.act_ready = (state == S_COMPUTE) && (accepted != num_q) && (!in_flight || last_bit);
      bus.res_valid = (state == S_DRAIN);

      wt_fire  = bus.wt_ready && bus.wt_valid;
      act_fire = bus.act_ready && bus.act_valid;
      res_fire = bus.res_valid && bus.res_ready;

      busy = (state != S_IDLE);
      done = done_q || res_fire;

      bus.res_data = '0;
      for (int unsigned s = 0; s < NUM_STACKS; s++)
         bus.res_data[s*ACC_WIDTH +: ACC_WIDTH] = acc[s];
   end

   // Per-stack bit-plane partial sum and accumulator update with overflow detect
   always_comb begin
      act_word = '0;
      act_col  = '0;
      sum_hi   = '0;
      acc_ovf  = '0;
      for (int unsigned s = 0; s < NUM_STACKS; s++) begin
         psum[s] = '0;
         for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            act_word = shadow[(s*NUM_INPUTS+i)*ACT_WIDTH +: ACT_WIDTH];
            act_col  = act_word >> bit_idx;
            if (act_col[0])
               psum[s] = psum[s] + PW'(weights[s][i]);
         end
         term[s] = TW'(psum[s]) <<< bit_idx;
         sum[s]  = neg_bit ? (TW'(acc[s]) - term[s]) : (TW'(acc[s]) + term[s]);
         // In range iff every bit from the ACC sign position upward agrees.
         sum_hi     = sum[s][TW-1:ACC_WIDTH-1];
         acc_ovf[s] = !((&sum_hi) || !(|sum_hi));
`ifdef CIM_MAC_SATURATE_EN
         if (acc_ovf[s])
            acc_next[s] = sum[s][TW-1] ? ACC_NEG : ACC_POS;
         else
            acc_next[s] = sum[s][ACC_WIDTH-1:0];
`else
         acc_next[s] = sum[s][ACC_WIDTH-1:0];
`endif
      end
   end

   // Control FSM, job configuration latch, vector shadow and bit sequencing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         last_idx_q <= '0;
         bit_idx    <= '0;
         signed_q   <= 1'b0;
         num_q      <= '0;
         accepted   <= '0;
         in_flight  <= 1'b0;
         wt_beat    <= '0;
         done_q     <= 1'b0;
         shadow     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (!start_ok) begin
                     done_q <= 1'b1;
                  end else begin
                     last_idx_q <= cfg_act_bits - AB_W'(1);
                     signed_q   <= cfg_signed;
                     num_q      <= cfg_num_vec;
                     accepted   <= '0;
                     in_flight  <= 1'b0;
                     bit_idx    <= '0;
                     wt_beat    <= '0;
                     state      <= cfg_reload_wt ? S_LOAD_W : S_COMPUTE;
                  end
               end
            end
            S_LOAD_W: begin
               if (wt_fire) begin
                  wt_beat <= wt_beat + IDX_W'(1);
                  if (wt_beat == LAST_ROW)
                     state <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               // A new vector may be taken on the last bit of the current one,
               // so its bit 0 follows with no bubble.
               if (act_fire) begin
                  shadow    <= bus.act_data;
                  accepted  <= accepted + VEC_CNT_W'(1);
                  in_flight <= 1'b1;
                  bit_idx   <= '0;
               end else if (in_flight) begin
                  if (last_bit) begin
                     in_flight <= 1'b0;
                     if (accepted == num_q)
                        state <= S_DRAIN;
                  end else begin
                     bit_idx <= bit_idx + AB_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (res_fire)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Weight storage: beat k writes row k of every stack
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned s = 0; s < NUM_STACKS; s++)
            for (int unsigned i = 0; i < NUM_INPUTS; i++)
               weights[s][i] <= '0;
      end else if (wt_fire) begin
         for (int unsigned s = 0; s < NUM_STACKS; s++)
            weights[s][wt_beat] <= bus.wt_data[s*WT_WIDTH +: WT_WIDTH];
      end
   end

   // Accumulators and sticky overflow: cleared on a legal start, updated per bit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned s = 0; s < NUM_STACKS; s++)
            acc[s] <= '0;
         overflow <= '0;
      end else if ((state == S_IDLE) && start && start_ok) begin
         for (int unsigned s = 0; s < NUM_STACKS; s++)
            acc[s] <= '0;
         overflow <= '0;
      end else if ((state == S_COMPUTE) && in_flight) begin
         for (int unsigned s = 0; s < NUM_STACKS; s++) begin
            acc[s] <= acc_next[s];
            if (acc_ovf[s])
               overflow[s] <= 1'b1;
         end
      end
   end

endmodule
